// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi
//  Description : Multi-channel PWM generator. A shared prescaler produces a
//                one-cycle pwm_step every PERIOD_TICKS clocks; a shared N-bit
//                step counter (edge-aligned sawtooth or center-aligned
//                triangle) feeds CHANNELS duty comparators. Duty values are
//                double-buffered and only become active at a period boundary.
//                Optional macro PWM_DEADTIME_EN adds complementary outputs
//                pwm_out_n with DEAD_CYCLES of rising-edge dead time.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int N            = 4,
    parameter int M            = 7,
    parameter int PERIOD_TICKS = 120,
    parameter int CHANNELS     = 2
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEAD_CYCLES  = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  center_mode,
    input  logic [CHANNELS-1:0]   duty_wr,
    input  logic [CHANNELS*N-1:0] duty_in,
    output logic                  pwm_step,
    output logic                  period_start,
    output logic [CHANNELS-1:0]   pwm_out
`ifdef PWM_DEADTIME_EN
    ,
    output logic [CHANNELS-1:0]   pwm_out_n
`endif
);

    localparam logic [M-1:0] c_TICK_LAST = M'(PERIOD_TICKS - 1);
    localparam logic [N-1:0] c_CNT_MAX   = {N{1'b1}};
    localparam logic [N-1:0] c_CNT_ONE   = N'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [M-1:0] r_ticks;
    logic         r_step;
    logic [N-1:0] r_cnt;
    dir_t         r_dir;
    logic         r_mode;
    logic         r_pstart;
    logic [N-1:0] r_shadow [CHANNELS];
    logic [N-1:0] r_active [CHANNELS];
    logic [N-1:0] w_duty   [CHANNELS];
    logic [CHANNELS-1:0] w_raw;
    logic         w_bnd;

    // Unpack the flat duty bus and form the raw per-channel comparison
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_duty[gi] = duty_in[gi*N +: N];
            assign w_raw[gi]  = ena & (r_cnt < r_active[gi]);
        end
    endgenerate

    // A boundary is the step that returns the counter to zero
    assign w_bnd = r_step & (r_mode ? ((r_cnt == c_CNT_ONE) && (r_dir == DIR_DOWN))
                                    : (r_cnt == c_CNT_MAX));

    // Prescaler: ticks wrap at PERIOD_TICKS-1 and emit a registered step pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ticks <= '0;
            r_step  <= 1'b0;
        end else if (ena) begin
            if (r_ticks == c_TICK_LAST) begin
                r_ticks <= '0;
                r_step  <= 1'b1;
            end else begin
                r_ticks <= r_ticks + M'(1);
                r_step  <= 1'b0;
            end
        end else begin
            r_step  <= 1'b0;
        end
    end

    // Step counter: sawtooth or triangle; mode is latched only at a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
            r_mode   <= 1'b0;
            r_pstart <= 1'b0;
        end else begin
            r_pstart <= w_bnd;
            if (r_step) begin
                if (w_bnd) begin
                    r_cnt  <= '0;
                    r_dir  <= DIR_UP;
                    r_mode <= center_mode;
                end else if (!r_mode) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end else if (r_dir == DIR_UP) begin
                    if (r_cnt == c_CNT_MAX) begin
                        r_cnt <= c_CNT_MAX - c_CNT_ONE;
                        r_dir <= DIR_DOWN;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end else begin
                    // Going down at zero cannot happen after a boundary, but
                    // recover to a legal triangle position if it ever does
                    if (r_cnt == '0) begin
                        r_cnt <= c_CNT_ONE;
                        r_dir <= DIR_UP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
            end
        end
    end

    // Double-buffered duty: shadow takes writes any time, active at boundary
    // (a write coinciding with the boundary goes straight through)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_wr[i]) begin
                    r_shadow[i] <= w_duty[i];
                end
                if (w_bnd) begin
                    r_active[i] <= duty_wr[i] ? w_duty[i] : r_shadow[i];
                end
            end
        end
    end

    assign pwm_step     = r_step;
    assign period_start = r_pstart;

`ifdef PWM_DEADTIME_EN
    localparam int c_DW = $clog2(DEAD_CYCLES + 2);
    localparam logic [c_DW-1:0] c_DEAD = c_DW'(DEAD_CYCLES);

    logic [c_DW-1:0]     r_run_hi [CHANNELS];
    logic [c_DW-1:0]     r_run_lo [CHANNELS];
    logic [CHANNELS-1:0] r_pwm_p;
    logic [CHANNELS-1:0] r_pwm_n;

    // Dead time: each side rises only after its level has been stable for
    // DEAD_CYCLES clocks; falling edges are immediate, so the pair never overlaps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_p <= '0;
            r_pwm_n <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_run_hi[i] <= '0;
                r_run_lo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_raw[i]) begin
                    r_run_lo[i] <= '0;
                    r_pwm_n[i]  <= 1'b0;
                    if (r_run_hi[i] < c_DEAD) begin
                        r_run_hi[i] <= r_run_hi[i] + c_DW'(1);
                    end
                    r_pwm_p[i] <= ((32'(r_run_hi[i]) + 32'd1) >= 32'(DEAD_CYCLES));
                end else begin
                    r_run_hi[i] <= '0;
                    r_pwm_p[i]  <= 1'b0;
                    if (r_run_lo[i] < c_DEAD) begin
                        r_run_lo[i] <= r_run_lo[i] + c_DW'(1);
                    end
                    r_pwm_n[i] <= ena &
                                  ((32'(r_run_lo[i]) + 32'd1) >= 32'(DEAD_CYCLES));
                end
            end
        end
    end

    assign pwm_out   = r_pwm_p;
    assign pwm_out_n = r_pwm_n;
`else
    logic [CHANNELS-1:0] r_pwm;

    // Registered comparator outputs, one clock behind the step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_raw;
        end
    end

    assign pwm_out = r_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi
//  Description : Self-checking bench for pwm_multi. A period-position model
//                predicts pwm_step, period_start and pwm_out every cycle, and
//                per-period high-time totals are checked against closed-form
//                duty arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int N   = 4;
    localparam int M   = 7;
    localparam int PT  = 120;
    localparam int CH  = 2;
    localparam int MAXC = (1 << N) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic            center_mode;
    logic [CH-1:0]   duty_wr;
    logic [CH*N-1:0] duty_in;
    logic            pwm_step;
    logic            period_start;
    logic [CH-1:0]   pwm_out;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multi #(
        .N            (N),
        .M            (M),
        .PERIOD_TICKS (PT),
        .CHANNELS     (CH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .center_mode  (center_mode),
        .duty_wr      (duty_wr),
        .duty_in      (duty_in),
        .pwm_step     (pwm_step),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: position within the period ----------
    int m_ticks, m_pos, m_mode;
    int m_step, m_ps;
    int m_out [CH];
    int m_sh  [CH];
    int m_act [CH];

    function automatic int period_len(input int mode);
        return mode ? 2 * MAXC : MAXC + 1;
    endfunction

    function automatic int cnt_of(input int pos, input int mode);
        if (mode && pos > MAXC) return 2 * MAXC - pos;
        return pos;
    endfunction

    always @(posedge clk) begin
        int c, bnd, nstep;
        if (rst) begin
            m_ticks = 0; m_pos = 0; m_mode = 0; m_step = 0; m_ps = 0;
            for (int i = 0; i < CH; i++) begin
                m_out[i] = 0; m_sh[i] = 0; m_act[i] = 0;
            end
        end else begin
            c   = cnt_of(m_pos, m_mode);
            bnd = (m_step != 0) && (m_pos == period_len(m_mode) - 1);
            for (int i = 0; i < CH; i++) m_out[i] = (ena && c < m_act[i]) ? 1 : 0;
            m_ps = bnd;
            if (m_step != 0) begin
                if (bnd) begin
                    m_pos  = 0;
                    m_mode = center_mode;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (bnd) m_act[i] = duty_wr[i] ? int'(duty_in[i*N +: N]) : m_sh[i];
                if (duty_wr[i]) m_sh[i] = int'(duty_in[i*N +: N]);
            end
            nstep = (ena && m_ticks == PT - 1) ? 1 : 0;
            if (ena) m_ticks = (m_ticks == PT - 1) ? 0 : m_ticks + 1;
            m_step = nstep;
        end
    end

    // ---------------- per-cycle and per-period checks ----------------------
    int hi_cnt [CH];
    int win_exp [CH];
    int win_valid = 0;

    always @(negedge clk) begin
        check_eq("pwm_step", 32'(pwm_step), 32'(m_step));
        check_eq("period_start", 32'(period_start), 32'(m_ps));
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("pwm_out%0d", i), 32'(pwm_out[i]), 32'(m_out[i]));
            hi_cnt[i] += int'(pwm_out[i]);
        end
        if (rst || !ena) begin
            win_valid = 0;
        end else if (period_start === 1'b1) begin
            for (int i = 0; i < CH; i++) begin
                if (win_valid) check_eq($sformatf("period_high%0d", i), 32'(hi_cnt[i]), 32'(win_exp[i]));
                hi_cnt[i]  = 0;
                // edge: d of 2^N steps; center: cnt<d on the way up and down
                if (m_mode) win_exp[i] = (m_act[i] == 0) ? 0 : (2 * m_act[i] - 1) * PT;
                else        win_exp[i] = m_act[i] * PT;
            end
            win_valid = 1;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_duty(input logic [CH-1:0] mask, input int d0, input int d1);
        duty_in = {4'(d1), 4'(d0)};
        duty_wr = mask;
        @(negedge clk);
        duty_wr = '0;
    endtask

    // Wait (at a negedge) until the next posedge is a boundary event
    task automatic wait_boundary_next();
        int k;
        k = 0;
        while (!(m_step != 0 && m_pos == period_len(m_mode) - 1) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 8000) check_eq("boundary_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; center_mode = 1'b0; duty_wr = '0; duty_in = '0;
        for (int i = 0; i < CH; i++) begin hi_cnt[i] = 0; win_exp[i] = 0; end
        cycles(3);
        rst = 1'b0;
        ena = 1'b1;
        // edge mode, ch0=4, ch1=12 right after reset
        write_duty(2'b11, 4, 12);
        cycles(4 * 1920);
        // mid-period write: takes effect at next boundary
        cycles(700);
        write_duty(2'b01, 8, 0);
        cycles(2 * 1920);
        // write exactly on the boundary cycle: write-through
        wait_boundary_next();
        write_duty(2'b10, 0, 3);
        cycles(2 * 1920);
        // center mode, duty 8
        center_mode = 1'b1;
        write_duty(2'b11, 8, 15);
        cycles(3 * 3600);
        // drop ena for 500 clks mid-period
        cycles(1000);
        ena = 1'b0;
        write_duty(2'b01, 5, 0);
        cycles(499);
        ena = 1'b1;
        cycles(3 * 3600);
        // randomized writes, mode changes and short ena drops
        for (int it = 0; it < 14; it++) begin
            cycles($urandom_range(1, 3000));
            case ($urandom_range(0, 3))
                0, 1: write_duty(2'($urandom_range(1, 3)), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
                2:    center_mode = 1'($urandom_range(0, 1));
                default: begin
                    ena = 1'b0;
                    cycles($urandom_range(1, 200));
                    ena = 1'b1;
                end
            endcase
        end
        cycles(4000);
        // one-clock reset mid-period, then run from cleared state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycles(2000);
        write_duty(2'b11, 15, 1);
        cycles(2 * 1920 + 500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
